// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the DMA transmit buffer.
//   - Region selection: the top address bit picks data (FIFO) or registers.
//   - Register offsets within the register window (adr[1:0]).
//   - Bit positions of the STAT register and of the clear mask written to it.
//   - Saturating 16-bit increment used by the event counters.
package dma_pkg;

  // Value of address bit DMA_AWIDTH-1 for each region.
  localparam logic REGION_DATA = 1'b0;
  localparam logic REGION_REG  = 1'b1;

  // Register window offsets (adr[1:0]).
  typedef enum logic [1:0] {
    REG_LEVEL = 2'd0,
    REG_OVF   = 2'd1,
    REG_UNF   = 2'd2,
    REG_STAT  = 2'd3
  } reg_sel_e;

  // STAT register bit positions.
  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_LOW   = 2;

  // Clear mask bits written to the STAT offset.
  localparam int unsigned CLR_OVF = 0;
  localparam int unsigned CLR_UNF = 1;

  localparam int unsigned CNT_W = 16;

  function automatic logic [CNT_W-1:0] sat_inc16(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dma_sdpram.sv
// dma_sdpram: simple dual-port RAM backing the transmit FIFO.
//   clk_i            clock
//   rst_ni           synchronous active-low reset (read register only)
//   we_i/waddr_i/wdata_i  synchronous write port
//   re_i/raddr_i/rdata_o  synchronous read port; rdata_o holds when re_i low
//   haddr_i/hdata_o  asynchronous read port for the FIFO head
// Memory contents are not reset.
module dma_sdpram #(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o,
  input  logic [AWIDTH-1:0] haddr_i,
  output logic [DWIDTH-1:0] hdata_o
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

  assign hdata_o = mem[haddr_i];

endmodule

// File: rtl/dma_tx_buffer.sv
// dma_tx_buffer: DMA-bus responder feeding the S/PDIF transmitter.
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   dma_en_i     read strobe
//   dma_we_i     write strobe (a write regardless of dma_en_i)
//   dma_adr_i    word address; MSB selects data (0) or registers (1)
//   dma_dat_i    write data
//   dma_dat_o    registered read data, held between reads
//   tx_dat_o     FIFO head sample, zero when empty
//   tx_valid_o   FIFO not empty
//   tx_ready_i   transmitter consumes the head this cycle
//   low_water_o  one-cycle pulse when level falls to LOW_WATER or below
module dma_tx_buffer
  import dma_pkg::*;
#(
  parameter int unsigned DMA_DWIDTH = 64,
  parameter int unsigned DMA_AWIDTH = 12,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LOW_WATER  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dma_en_i,
  input  logic                  dma_we_i,
  input  logic [DMA_AWIDTH-1:0] dma_adr_i,
  input  logic [DMA_DWIDTH-1:0] dma_dat_i,
  output logic [DMA_DWIDTH-1:0] dma_dat_o,
  output logic [DMA_DWIDTH-1:0] tx_dat_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  low_water_o
);

  localparam logic [DEPTH_LOG2:0] DEPTH_L = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LOW_L   = (DEPTH_LOG2+1)'(LOW_WATER);

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, peek_addr;
  logic [DEPTH_LOG2:0]   level, level_nxt;
  logic [CNT_W-1:0]      ovf_cnt, unf_cnt;
  logic                  low_q;

  logic region, full, empty, low;
  logic pop, underflow, push_req, push_acc, ovf_evt;
  logic rd_data, rd_reg, wr_stat, clr_ovf, clr_unf;
  logic ram_we, ram_re;

  logic [DMA_DWIDTH-1:0] ram_rdata, head_data, reg_rdata, reg_q, stat_word;
  logic                  src_reg_q;

  // Only the region bit, the peek offset and the register select are decoded.
  logic unused_adr_bits;
  assign unused_adr_bits = ^dma_adr_i;

  always_comb begin
    region    = dma_adr_i[DMA_AWIDTH-1];
    full      = (level == DEPTH_L);
    empty     = (level == '0);
    low       = (level <= LOW_L);

    pop       = ~empty & tx_ready_i;
    underflow = empty & tx_ready_i;

    push_req  = dma_we_i & (region == REGION_DATA);
    // A same-cycle pop frees a slot, so a full FIFO still accepts the word.
    push_acc  = push_req & (~full | pop);
    ovf_evt   = push_req & ~push_acc;

    rd_data   = dma_en_i & ~dma_we_i & (region == REGION_DATA);
    rd_reg    = dma_en_i & ~dma_we_i & (region == REGION_REG);
    wr_stat   = dma_we_i & (region == REGION_REG) & (dma_adr_i[1:0] == REG_STAT);
    clr_ovf   = wr_stat & dma_dat_i[CLR_OVF];
    clr_unf   = wr_stat & dma_dat_i[CLR_UNF];

    peek_addr = rd_ptr + dma_adr_i[DEPTH_LOG2-1:0];

    unique case ({push_acc, pop})
      2'b10:   level_nxt = level + (DEPTH_LOG2+1)'(1);
      2'b01:   level_nxt = level - (DEPTH_LOG2+1)'(1);
      default: level_nxt = level;
    endcase

    stat_word             = '0;
    stat_word[STAT_FULL]  = full;
    stat_word[STAT_EMPTY] = empty;
    stat_word[STAT_LOW]   = low;

    reg_rdata = '0;
    case (reg_sel_e'(dma_adr_i[1:0]))
      REG_LEVEL: reg_rdata = DMA_DWIDTH'(level);
      REG_OVF:   reg_rdata = DMA_DWIDTH'(ovf_cnt);
      REG_UNF:   reg_rdata = DMA_DWIDTH'(unf_cnt);
      REG_STAT:  reg_rdata = stat_word;
      default:   reg_rdata = '0;
    endcase

    ram_we = push_acc & rst_ni;
    ram_re = rd_data & rst_ni;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ovf_cnt   <= '0;
      unf_cnt   <= '0;
      low_q     <= 1'b0;
      reg_q     <= '0;
      src_reg_q <= 1'b1;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      level <= level_nxt;

      if (clr_ovf) begin
        ovf_cnt <= '0;
      end else if (ovf_evt) begin
        ovf_cnt <= sat_inc16(ovf_cnt);
      end

      if (clr_unf) begin
        unf_cnt <= '0;
      end else if (underflow) begin
        unf_cnt <= sat_inc16(unf_cnt);
      end

      low_q <= (level > LOW_L) && (level_nxt <= LOW_L);

      // Register reads are captured here, data peeks inside the RAM; the
      // source flag remembers which of the two registers is the live result.
      if (rd_reg) begin
        reg_q     <= reg_rdata;
        src_reg_q <= 1'b1;
      end else if (rd_data) begin
        src_reg_q <= 1'b0;
      end
    end
  end

  dma_sdpram #(
    .DWIDTH (DMA_DWIDTH),
    .AWIDTH (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (ram_we),
    .waddr_i (wr_ptr),
    .wdata_i (dma_dat_i),
    .re_i    (ram_re),
    .raddr_i (peek_addr),
    .rdata_o (ram_rdata),
    .haddr_i (rd_ptr),
    .hdata_o (head_data)
  );

  assign dma_dat_o   = src_reg_q ? reg_q : ram_rdata;
  assign tx_valid_o  = ~empty;
  assign tx_dat_o    = empty ? '0 : head_data;
  assign low_water_o = low_q;

endmodule
